// File: rtl/uart_tx_frame_ctrl_if.sv
// Transmit-side handshake and serial output of the UART framer.
// The source drives Start/Data/Parity_Odd and watches Busy/Done; So goes to the pin.
interface uart_tx_frame_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              Start;
    logic [DATA_W-1:0] Data;
    logic              Parity_Odd;
    logic              So;
    logic              Busy;
    logic              Done;

    modport master (output Start, Data, Parity_Odd, input So, Busy, Done);
    modport slave  (input Start, Data, Parity_Odd, output So, Busy, Done);
endinterface

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit framer: start bit, DATA_W data bits LSB first, optional parity,
// STOP_BITS stop bits, each held for CLK_DIV clocks; Start/Busy/Done handshake.
module uart_tx_frame_ctrl #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 16,
    parameter int PARITY_EN = 1,
    parameter int STOP_BITS = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    uart_tx_frame_ctrl_if.slave   bus
);

    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] DATA_LAST  = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] STOP_LAST  = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                par_q, par_d;
    logic                so_q, so_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                bit_end;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            so_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            so_q    <= so_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // NOTE: every signal gets a default at the top so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        done_d  = 1'b0;
        bit_end = (cnt_q == '0);

        unique case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    shreg_d = bus.Data;
                    par_d   = (^bus.Data) ^ bus.Parity_Odd;
                    cnt_d   = CNT_RELOAD;
                    idx_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Bit timer runs in every bit state and reloads at the end of each bit.
        if (state_q != IDLE) begin
            cnt_d = bit_end ? CNT_RELOAD : cnt_q - 1'b1;
        end

        // Outputs are decoded from the next state so they register in step with it.
        unique case (state_d)
            START:   so_d = 1'b0;
            DATA:    so_d = shreg_d[0];
            PARITY:  so_d = par_d;
            default: so_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign bus.So   = so_q;
    assign bus.Busy = busy_q;
    assign bus.Done = done_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: three configurations, hand-written frame table,
// multi-cycle corner sequences and randomized frames against a bit-list model.
module tb_uart_tx_frame_ctrl;

    localparam int DIV = 4;
    // Configurations: 0 = 8 data, parity, 1 stop; 1 = 8 data, parity, 2 stop; 2 = 7 data, no parity, 1 stop.
    localparam int CFG_DW [3] = '{8, 8, 7};
    localparam int CFG_PE [3] = '{1, 1, 0};
    localparam int CFG_SB [3] = '{1, 2, 1};

    typedef bit frame_q_t[$];

    typedef struct {
        int         k;
        logic [7:0] data;
        logic       odd;
        string      exp;
        string      name;
    } vec_t;

    logic       Clk;
    logic       Reset;
    logic       start_v [3];
    logic [7:0] data_v  [3];
    logic       odd_v   [3];

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_frame_ctrl_if #(.DATA_W(8)) if0 ();
    uart_tx_frame_ctrl_if #(.DATA_W(8)) if1 ();
    uart_tx_frame_ctrl_if #(.DATA_W(7)) if2 ();

    assign if0.Start = start_v[0];  assign if0.Data = data_v[0];       assign if0.Parity_Odd = odd_v[0];
    assign if1.Start = start_v[1];  assign if1.Data = data_v[1];       assign if1.Parity_Odd = odd_v[1];
    assign if2.Start = start_v[2];  assign if2.Data = data_v[2][6:0];  assign if2.Parity_Odd = odd_v[2];

    uart_tx_frame_ctrl #(.DATA_W(CFG_DW[0]), .CLK_DIV(DIV), .PARITY_EN(CFG_PE[0]), .STOP_BITS(CFG_SB[0]))
        dut0 (.Clk(Clk), .Reset(Reset), .bus(if0));
    uart_tx_frame_ctrl #(.DATA_W(CFG_DW[1]), .CLK_DIV(DIV), .PARITY_EN(CFG_PE[1]), .STOP_BITS(CFG_SB[1]))
        dut1 (.Clk(Clk), .Reset(Reset), .bus(if1));
    uart_tx_frame_ctrl #(.DATA_W(CFG_DW[2]), .CLK_DIV(DIV), .PARITY_EN(CFG_PE[2]), .STOP_BITS(CFG_SB[2]))
        dut2 (.Clk(Clk), .Reset(Reset), .bus(if2));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic so_of(int k);
        case (k)
            0:       return if0.So;
            1:       return if1.So;
            default: return if2.So;
        endcase
    endfunction

    function automatic logic busy_of(int k);
        case (k)
            0:       return if0.Busy;
            1:       return if1.Busy;
            default: return if2.Busy;
        endcase
    endfunction

    function automatic logic done_of(int k);
        case (k)
            0:       return if0.Done;
            1:       return if1.Done;
            default: return if2.Done;
        endcase
    endfunction

    // Hand-written frame: '0'/'1' per bit slot, '_' ignored as a separator.
    function automatic frame_q_t parse_frame(string s);
        frame_q_t q;
        byte c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c == "0") q.push_back(1'b0);
            else if (c == "1") q.push_back(1'b1);
        end
        return q;
    endfunction

    // Reference model: list of line levels, one per bit time.
    function automatic frame_q_t model_frame(int k, logic [7:0] data, logic odd);
        frame_q_t q;
        bit par;
        par = odd;
        q.push_back(1'b0);
        for (int i = 0; i < CFG_DW[k]; i++) begin
            q.push_back(data[i]);
            par ^= data[i];
        end
        if (CFG_PE[k] != 0) q.push_back(par);
        for (int i = 0; i < CFG_SB[k]; i++) q.push_back(1'b1);
        return q;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic check_idle(input int k, input string name);
        check({name, " so"},   32'(so_of(k)),   32'd1);
        check({name, " busy"}, 32'(busy_of(k)), 32'd0);
        check({name, " done"}, 32'(done_of(k)), 32'd0);
    endtask

    // Holds Start across one edge; returns in the first frame cycle.
    task automatic launch(input int k, input logic [7:0] d, input logic o);
        start_v[k] = 1'b1;
        data_v[k]  = d;
        odd_v[k]   = o;
        tick;
        start_v[k] = 1'b0;
        data_v[k]  = 8'($urandom);
        odd_v[k]   = 1'($urandom);
    endtask

    // Checks every frame cycle, scrambling Data meanwhile; optionally pulses Start
    // at frame cycle jab_at. Returns in the Done cycle.
    task automatic watch(input int k, input frame_q_t exp, input string name,
                         input int jab_at, input logic [7:0] jab_data);
        int n;
        n = exp.size() * DIV;
        for (int c = 0; c < n; c++) begin
            check({name, " so"},   32'(so_of(k)),   32'(exp[c / DIV]));
            check({name, " busy"}, 32'(busy_of(k)), 32'd1);
            check({name, " done"}, 32'(done_of(k)), 32'd0);
            if (c == jab_at) begin
                start_v[k] = 1'b1;
                data_v[k]  = jab_data;
            end else begin
                data_v[k] = 8'($urandom);
            end
            odd_v[k] = 1'($urandom);
            tick;
            start_v[k] = 1'b0;
        end
        check({name, " done pulse"}, 32'(done_of(k)), 32'd1);
        check({name, " done busy"},  32'(busy_of(k)), 32'd0);
        check({name, " done so"},    32'(so_of(k)),   32'd1);
    endtask

    task automatic after_frame(input int k, input string name);
        tick;
        check_idle(k, {name, " after"});
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{k: 0, data: 8'hA5, odd: 1'b0, exp: "0_10100101_0_1",  name: "a5 even"};
        vecs[1] = '{k: 0, data: 8'hFF, odd: 1'b1, exp: "0_11111111_1_1",  name: "ff odd"};
        vecs[2] = '{k: 0, data: 8'h01, odd: 1'b0, exp: "0_10000000_1_1",  name: "01 even"};
        vecs[3] = '{k: 1, data: 8'hA5, odd: 1'b1, exp: "0_10100101_1_11", name: "a5 odd 2stop"};
        vecs[4] = '{k: 1, data: 8'h80, odd: 1'b1, exp: "0_00000001_0_11", name: "80 odd 2stop"};
        vecs[5] = '{k: 2, data: 8'h7F, odd: 1'b0, exp: "0_1111111_1",     name: "7f nopar"};
        vecs[6] = '{k: 2, data: 8'hAA, odd: 1'b1, exp: "0_0101010_1",     name: "2a nopar"};

        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0;
            data_v[k]  = 8'h00;
            odd_v[k]   = 1'b0;
        end

        // Reset held for three cycles, then twenty quiet cycles.
        Reset = 1'b0;
        repeat (3) tick;
        for (int k = 0; k < 3; k++) check_idle(k, "in reset");
        Reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick;
            for (int k = 0; k < 3; k++) check_idle(k, "post reset");
        end

        foreach (vecs[i]) begin
            launch(vecs[i].k, vecs[i].data, vecs[i].odd);
            watch(vecs[i].k, parse_frame(vecs[i].exp), vecs[i].name, -1, 8'h00);
            after_frame(vecs[i].k, vecs[i].name);
            repeat (2) tick;
        end

        // Back-to-back: second Start raised in the Done cycle.
        launch(1, 8'hA5, 1'b1);
        watch(1, parse_frame("0_10100101_1_11"), "b2b first", -1, 8'h00);
        launch(1, 8'h00, 1'b0);
        watch(1, parse_frame("0_00000000_0_11"), "b2b second", -1, 8'h00);
        after_frame(1, "b2b");

        // Start while busy must be ignored, with no frame following.
        launch(0, 8'hA5, 1'b0);
        watch(0, parse_frame("0_10100101_0_1"), "busy start", 10, 8'h3C);
        for (int c = 0; c < 8; c++) after_frame(0, "busy start");

        // Reset in the middle of the data bits, then a clean frame.
        launch(0, 8'hA5, 1'b0);
        repeat (12) tick;
        check("mid busy before reset", 32'(busy_of(0)), 32'd1);
        Reset = 1'b0;
        #1;
        check_idle(0, "async reset");
        repeat (2) tick;
        check_idle(0, "held reset");
        Reset = 1'b1;
        tick;
        check_idle(0, "reset release");
        launch(0, 8'h55, 1'b0);
        watch(0, parse_frame("0_10101010_0_1"), "55 after reset", -1, 8'h00);
        after_frame(0, "55 after reset");

        // Randomized frames against the model, with optional busy Start and chaining.
        for (int it = 0; it < 40; it++) begin
            int         k;
            int         jab;
            logic [7:0] d;
            logic       o;
            k   = $urandom_range(0, 2);
            d   = 8'($urandom);
            o   = 1'($urandom);
            jab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 35) : -1;
            launch(k, d, o);
            watch(k, model_frame(k, d, o), "rand", jab, 8'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                d = 8'($urandom);
                o = 1'($urandom);
                launch(k, d, o);
                watch(k, model_frame(k, d, o), "rand b2b", -1, 8'h00);
            end
            after_frame(k, "rand");
            repeat ($urandom_range(0, 3)) tick;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
